// File: rtl/led7_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
package led7_pkg;

  localparam logic [6:0] LED7_BLANK = 7'b1111111;
  localparam int unsigned AN_MAX_W = 32;

  typedef logic [3:0] bcd_digit_t;

  // All-ones anode mask of the requested width (anodes are active-low); callers cast to their width.
  function automatic logic [AN_MAX_W-1:0] AN_OFF(input int unsigned width);
    if (width >= AN_MAX_W) return '1;
    return (AN_MAX_W'(1) << width) - AN_MAX_W'(1);
  endfunction

endpackage

// File: rtl/led7_prescaler.sv
// Free-running divide-by-CLK_DIV counter; tick_c marks the last clock of each digit slot.
module led7_prescaler #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned PCNT_W = $clog2(CLK_DIV);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(CLK_DIV - 1);

  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] pcnt_next;

  assign tick_c = (pcnt == PCNT_MAX);

  always_comb begin
    pcnt_next = pcnt + PCNT_W'(1);
    if (tick_c) pcnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt <= '0;
    else     pcnt <= pcnt_next;
  end

endmodule

// File: rtl/led7_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display with
// frame-aligned double-buffered digit updates and optional leading-zero blanking.
module led7_scan_ctrl
  import led7_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [3:0]              bin_out,
  output logic                    seg_en,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame
);

  localparam int unsigned WORD_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic                  tick;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic [WORD_W-1:0]     pend_reg;
  logic [WORD_W-1:0]     disp_reg;
  logic [WORD_W-1:0]     shown_word;
  logic                  pend;
  logic                  commit;
  logic                  upper_nz;
  bcd_digit_t            bin_next;
  logic                  seg_en_next;
  logic [NUM_DIGITS-1:0] an_next;

  led7_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick)
  );

  // Next digit, commit decision and the output values for the upcoming slot.
  always_comb begin
    idx_next    = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    commit      = tick && (idx_next == '0) && pend;
    shown_word  = commit ? pend_reg : disp_reg;
    bin_next    = '0;
    upper_nz    = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (IDX_W'(j) == idx_next) bin_next = shown_word[4*j +: 4];
      // Any non-zero digit at or above the selected one means it is not a leading zero.
      if ((IDX_W'(j) >= idx_next) && (shown_word[4*j +: 4] != 4'd0)) upper_nz = 1'b1;
    end
    seg_en_next = !(blank_lz && (idx_next != '0) && !upper_nz);
    an_next     = ~(NUM_DIGITS'(1) << idx_next);
  end

  // A load on the commit edge wins the pend flag, so its data shows one frame later.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= IDX_LAST;
      pend_reg <= '0;
      disp_reg <= '0;
      pend     <= 1'b0;
      bin_out  <= '0;
      seg_en   <= 1'b0;
      an_out   <= NUM_DIGITS'(AN_OFF(NUM_DIGITS));
      frame    <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (tick) begin
        idx     <= idx_next;
        bin_out <= bin_next;
        seg_en  <= seg_en_next;
        an_out  <= an_next;
        frame   <= (idx_next == '0);
      end
      if (commit) begin
        disp_reg <= pend_reg;
        pend     <= 1'b0;
      end
      if (load) begin
        pend_reg <= digits_in;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led7_scan_ctrl.sv
// Self-checking bench for led7_scan_ctrl: cycle-by-cycle reference model, vector table,
// directed corner sequences and randomized traffic.
module tb_led7_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int ND      = 4;
  localparam int FRAME   = CLK_DIV * ND;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [3:0]  bin_out;
  logic        seg_en;
  logic [3:0]  an_out;
  logic        frame;

  led7_scan_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .NUM_DIGITS (ND)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .digits_in (digits_in),
    .blank_lz  (blank_lz),
    .bin_out   (bin_out),
    .seg_en    (seg_en),
    .an_out    (an_out),
    .frame     (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: t counts clock edges since reset release.
  int          t;
  logic [15:0] m_pend_w;
  logic [15:0] m_disp;
  bit          m_pend;
  logic [3:0]  e_an;
  logic [3:0]  e_bin;
  logic        e_seg;
  logic        e_frame;

  typedef struct {
    logic [15:0] word;
    logic        blz;
    logic [3:0]  seg;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Digit slot d starts at every CLK_DIV-th edge; a frame starts when d wraps to 0.
  task automatic model_edge();
    int d;
    if (rst) begin
      t = 0; m_pend_w = '0; m_disp = '0; m_pend = 0;
      e_an = 4'hF; e_bin = 4'h0; e_seg = 1'b0; e_frame = 1'b0;
    end else begin
      t++;
      e_frame = 1'b0;
      if (t % CLK_DIV == 0) begin
        d = (t / CLK_DIV - 1) % ND;
        if (d == 0 && m_pend) begin
          m_disp = m_pend_w;
          m_pend = 0;
        end
        e_an    = ~4'(1 << d);
        e_bin   = 4'(m_disp >> (4 * d));
        e_seg   = !(blank_lz && d != 0 && ((m_disp >> (4 * d)) == 16'h0));
        e_frame = (d == 0);
      end
      if (load) begin
        m_pend_w = digits_in;
        m_pend   = 1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [15:0] w);
    rst = r; load = l; digits_in = w;
    @(posedge clk);
    model_edge();
    #1;
    check("model_an_out", 32'(an_out), 32'(e_an));
    check("model_bin_out", 32'(bin_out), 32'(e_bin));
    check("model_seg_en", 32'(seg_en), 32'(e_seg));
    check("model_frame", 32'(frame), 32'(e_frame));
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 16'h0);
  endtask

  task automatic wait_frame();
    bit ok = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      if (frame === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check("wait_frame_timeout", 32'(ok), 32'd1);
  endtask

  // Called on the first cycle of a frame; walks all digit slots.
  task automatic check_frame(input logic [15:0] word, input logic [3:0] exp_seg);
    logic [3:0] ea;
    for (int k = 0; k < ND; k++) begin
      ea = ~4'(1 << k);
      check("frame_an_out", 32'(an_out), 32'(ea));
      check("frame_bin_out", 32'(bin_out), 32'(4'(word >> (4 * k))));
      check("frame_seg_en", 32'(seg_en), 32'(exp_seg[k]));
      if (k < ND - 1) idle(CLK_DIV);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{word: 16'h1234, blz: 1'b0, seg: 4'b1111};
    tbl[1] = '{word: 16'h0050, blz: 1'b1, seg: 4'b0011};
    tbl[2] = '{word: 16'h0000, blz: 1'b1, seg: 4'b0001};
    tbl[3] = '{word: 16'h0000, blz: 1'b0, seg: 4'b1111};
    tbl[4] = '{word: 16'h00A0, blz: 1'b1, seg: 4'b0011};
    tbl[5] = '{word: 16'h1000, blz: 1'b1, seg: 4'b1111};
    tbl[6] = '{word: 16'h0203, blz: 1'b1, seg: 4'b0111};

    rst = 1'b1; load = 1'b0; digits_in = 16'h0; blank_lz = 1'b0;
    t = 0; m_pend_w = '0; m_disp = '0; m_pend = 0;
    e_an = 4'hF; e_bin = 4'h0; e_seg = 1'b0; e_frame = 1'b0;

    // Reset and first tick.
    repeat (3) cyc(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < CLK_DIV - 1; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      check("reset_an_blank", 32'(an_out), 32'hF);
      check("reset_seg_off", 32'(seg_en), 32'h0);
      check("reset_bin_zero", 32'(bin_out), 32'h0);
    end
    cyc(1'b0, 1'b0, 16'h0);
    check("first_tick_an", 32'(an_out), 32'hE);
    check("first_tick_seg", 32'(seg_en), 32'h1);
    check("first_tick_bin", 32'(bin_out), 32'h0);
    check("first_tick_frame", 32'(frame), 32'h1);
    cyc(1'b0, 1'b0, 16'h0);
    check("frame_one_cycle", 32'(frame), 32'h0);

    // Vector table: load right after a frame start, check the following frame.
    foreach (tbl[i]) begin
      wait_frame();
      blank_lz = tbl[i].blz;
      cyc(1'b0, 1'b1, tbl[i].word);
      wait_frame();
      check_frame(tbl[i].word, tbl[i].seg);
    end

    // Two loads in one frame: last one wins.
    blank_lz = 1'b0;
    wait_frame();
    cyc(1'b0, 1'b1, 16'h1111);
    idle(1);
    cyc(1'b0, 1'b1, 16'h2222);
    wait_frame();
    check_frame(16'h2222, 4'hF);

    // Load on the commit edge: old word this frame, new word the next.
    for (int i = 0; i < FRAME && (t % FRAME) != (CLK_DIV - 1); i++) idle(1);
    check("collision_align", 32'(t % FRAME), 32'(CLK_DIV - 1));
    cyc(1'b0, 1'b1, 16'h9999);
    check("collision_frame", 32'(frame), 32'h1);
    check_frame(16'h2222, 4'hF);
    wait_frame();
    check_frame(16'h9999, 4'hF);

    // Reset while showing digit 2 discards pending data.
    begin
      bit found = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        idle(1);
        if (an_out === 4'b1011) begin
          found = 1;
          break;
        end
      end
      check("reach_digit2", 32'(found), 32'h1);
    end
    cyc(1'b0, 1'b1, 16'h5555);
    cyc(1'b1, 1'b0, 16'h0);
    check("midrst_an", 32'(an_out), 32'hF);
    check("midrst_seg", 32'(seg_en), 32'h0);
    check("midrst_bin", 32'(bin_out), 32'h0);
    wait_frame();
    check_frame(16'h0000, 4'hF);
    idle(FRAME);
    check("midrst_stays_zero", 32'(bin_out), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        l;
      logic [15:0] w;
      r = ($urandom_range(0, 399) == 0);
      l = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      w = 16'($urandom);
      w = w >> (4 * $urandom_range(0, 4));
      cyc(r, l, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
